// File: rtl/std_fp_div_seq.sv
// Sequential unsigned fixed-point divider: out = (left << FRACT_WIDTH) / right,
// restoring division, one quotient bit per cycle, go/done handshake.
// Optional macro STD_FP_DIV_SEQ_SAT_EN adds an overflow output and saturates
// the quotient when it does not fit in WIDTH bits.
module std_fp_div_seq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned INT_WIDTH   = 16,
  parameter int unsigned FRACT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done,
`ifdef STD_FP_DIV_SEQ_SAT_EN
  output logic             overflow,
`endif
  output logic             div_by_zero
);

  localparam int unsigned N     = WIDTH + FRACT_WIDTH;
  localparam int unsigned CNT_W = $clog2(N + 1);

  // Format sanity check at elaboration
  if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_cfg_err
    $error("std_fp_div_seq: INT_WIDTH + FRACT_WIDTH must equal WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   rem_sh;
  logic             q_bit;
  logic             unused_bits;

  // Top remainder bit is always clear after a step; upper quotient bits only feed saturation
  assign unused_bits = ^{rem_q[WIDTH], acc_q[N-1:WIDTH], ovf_q};

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, restoring-division step and result capture
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    rem_sh = {rem_q[WIDTH-1:0], dvd_q[N-1]};
    q_bit  = (rem_sh >= {1'b0, div_q});

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          dvd_d   = {left, {FRACT_WIDTH{1'b0}}};
          rem_d   = '0;
          acc_d   = '0;
          div_d   = right;
          cnt_d   = '0;
          zero_d  = (right == '0);
          state_d = (right == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        rem_d = q_bit ? (rem_sh - {1'b0, div_q}) : rem_sh;
        acc_d = {acc_q[N-2:0], q_bit};
        dvd_d = {dvd_q[N-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (zero_q) begin
          quo_d = '1;
          rmd_d = dvd_q[N-1 -: WIDTH];
          dbz_d = 1'b1;
          ovf_d = 1'b1;
        end else begin
          rmd_d = rem_q[WIDTH-1:0];
          dbz_d = 1'b0;
`ifdef STD_FP_DIV_SEQ_SAT_EN
          if (|acc_q[N-1:WIDTH]) begin
            quo_d = '1;
            ovf_d = 1'b1;
          end else begin
            quo_d = acc_q[WIDTH-1:0];
            ovf_d = 1'b0;
          end
`else
          quo_d = acc_q[WIDTH-1:0];
          ovf_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_quotient  = quo_q;
  assign out_remainder = rmd_q;
  assign done          = done_q;
  assign div_by_zero   = dbz_q;
`ifdef STD_FP_DIV_SEQ_SAT_EN
  assign overflow      = ovf_q;
`endif

endmodule

// File: tb/tb_std_fp_div_seq.sv
// Directed self-checking bench for std_fp_div_seq (WIDTH=32, FRACT_WIDTH=16).
module tb_std_fp_div_seq;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned FRACT_WIDTH = 16;
  localparam int unsigned N           = WIDTH + FRACT_WIDTH;
  localparam int          LAT         = N + 1;
  localparam int          II          = N + 2;

  logic        clk;
  logic        reset;
  logic        go;
  logic [31:0] left;
  logic [31:0] right;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;
  logic        done;
  logic        div_by_zero;
`ifdef STD_FP_DIV_SEQ_SAT_EN
  logic        overflow;
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int lat;
  int seen;

  std_fp_div_seq #(.WIDTH(32), .INT_WIDTH(16), .FRACT_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .left          (left),
    .right         (right),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .done          (done),
`ifdef STD_FP_DIV_SEQ_SAT_EN
    .overflow      (overflow),
`endif
    .div_by_zero   (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with a one-cycle go pulse; returns just after the sampling edge
  task automatic start(input logic [31:0] l, input logic [31:0] r);
    left  = l;
    right = r;
    go    = 1'b1;
    tick();
    go    = 1'b0;
  endtask

  task automatic wait_done(input int max, output int k_out);
    k_out = -1;
    for (int k = 1; k <= max; k++) begin
      tick();
      if (done) begin
        k_out = k;
        break;
      end
    end
  endtask

  // Check a completed result, then that done is a single-cycle pulse
  task automatic check_result(input string tag, input int lat_obs, input int lat_exp,
                              input logic [31:0] q, input logic [31:0] r,
                              input logic dbz, input logic ovf);
    chk({tag, "_latency"}, 32'(lat_obs), 32'(lat_exp));
    chk({tag, "_quotient"}, out_quotient, q);
    chk({tag, "_remainder"}, out_remainder, r);
    chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(dbz));
`ifdef STD_FP_DIV_SEQ_SAT_EN
    chk({tag, "_overflow"}, 32'(overflow), 32'(ovf));
`else
    if (ovf) begin
      // overflow is not visible without saturation
    end
`endif
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_quotient_hold"}, out_quotient, q);
  endtask

  // go held high: operands corrupted mid-BUSY and restored before the next sample
  task automatic run_held(output int k_out);
    k_out = -1;
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (k == 5) begin
        left  = 32'hDEAD_BEEF;
        right = 32'h0000_0005;
      end
      if (k == 40) begin
        left  = 32'h0003_0000;
        right = 32'h0002_0000;
      end
      if (done) begin
        k_out = k;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    go    = 1'b0;
    left  = '0;
    right = '0;
    repeat (3) tick();
    chk("reset_quotient", out_quotient, 32'h0);
    chk("reset_remainder", out_remainder, 32'h0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_done", 32'(done), 32'd0);

    // 3.0 / 2.0 = 1.5
    start(32'h0003_0000, 32'h0002_0000);
    wait_done(200, lat);
    check_result("div_3_2", lat, LAT, 32'h0001_8000, 32'h0, 1'b0, 1'b0);

    // 1.0 / 3.0
    start(32'h0001_0000, 32'h0003_0000);
    wait_done(200, lat);
    check_result("div_1_3", lat, LAT, 32'h0000_5555, 32'h0001_0000, 1'b0, 1'b0);

    // Quotient too large for 32 bits: truncation or saturation
    start(32'h7FFF_0000, 32'h0000_0001);
    wait_done(200, lat);
    check_result("div_ovf", lat, LAT, SAT ? 32'hFFFF_FFFF : 32'h0, 32'h0, 1'b0, SAT);

    // Divide by zero
    start(32'h1234_0000, 32'h0);
    wait_done(10, lat);
    check_result("div_zero", lat, 1, 32'hFFFF_FFFF, 32'h1234_0000, 1'b1, 1'b1);

    // Abort a division with reset
    start(32'h0003_0000, 32'h0002_0000);
    repeat (9) tick();
    reset = 1'b0;
    #1;
    chk("abort_quotient", out_quotient, 32'h0);
    chk("abort_remainder", out_remainder, 32'h0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    tick();
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_quotient_after", out_quotient, 32'h0);

    // 6.0 / 2.0 after the abort
    start(32'h0006_0000, 32'h0002_0000);
    wait_done(200, lat);
    check_result("div_6_2", lat, LAT, 32'h0003_0000, 32'h0, 1'b0, 1'b0);

    // Back-to-back with go held high
    left  = 32'h0003_0000;
    right = 32'h0002_0000;
    go    = 1'b1;
    tick();
    run_held(lat);
    chk("held1_latency", 32'(lat), 32'(LAT));
    chk("held1_quotient", out_quotient, 32'h0001_8000);
    chk("held1_remainder", out_remainder, 32'h0);
    run_held(lat);
    go = 1'b0;
    chk("held2_interval", 32'(lat), 32'(II));
    chk("held2_quotient", out_quotient, 32'h0001_8000);
    chk("held2_remainder", out_remainder, 32'h0);
    tick();
    chk("held2_done_pulse", 32'(done), 32'd0);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done) seen++;
    end
    chk("held_stop", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
